// File: rtl/button_round_ctrl.sv
// Round controller for a button game: arms a set of buttons, blinks a shared
// sparkle signal while waiting, and reports the first masked selection, a
// timeout, or an abort from the reed switch.
module button_round_ctrl #(
    parameter int unsigned N_BTN       = 4,
    parameter int unsigned SPARKLE_DIV = 12500000,
    parameter int unsigned TIMEOUT     = 500000000
) (
    input  logic                                      i_clk,
    input  logic                                      i_rst_n,
    input  logic                                      i_start,
    input  logic [N_BTN-1:0]                          i_mask,
    input  logic [N_BTN-1:0]                          i_select,
    input  logic                                      i_abort,
    input  logic                                      i_ready,
    output logic [N_BTN-1:0]                          o_exist,
    output logic                                      o_sparkle,
    output logic                                      o_busy,
    output logic                                      o_valid,
    output logic [((N_BTN > 1) ? $clog2(N_BTN) : 1)-1:0] o_choice,
    output logic                                      o_timeout,
    output logic                                      o_abort
);

    localparam int unsigned CW = (N_BTN > 1) ? $clog2(N_BTN) : 1;
    localparam int unsigned SW = (SPARKLE_DIV > 1) ? $clog2(SPARKLE_DIV) : 1;

    typedef enum logic [1:0] {
        S_IDLE   = 2'd0,
        S_WAIT   = 2'd1,
        S_REPORT = 2'd2
    } state_t;

    state_t           state_q,   state_d;
    logic [N_BTN-1:0] mask_q,    mask_d;
    logic [31:0]      timer_q,   timer_d;
    logic [SW-1:0]    spk_cnt_q, spk_cnt_d;
    logic             sparkle_q, sparkle_d;
    logic [N_BTN-1:0] exist_q,   exist_d;
    logic             busy_q,    busy_d;
    logic             valid_q,   valid_d;
    logic [CW-1:0]    choice_q,  choice_d;
    logic             timeout_q, timeout_d;
    logic             abort_q,   abort_d;

    logic [N_BTN-1:0] hit;
    logic [CW-1:0]    sel_idx;

    // Masked selection and its lowest set index (priority encoder).
    always_comb begin
        hit     = i_select & mask_q;
        sel_idx = '0;
        for (int unsigned i = N_BTN; i > 0; i--) begin
            if (hit[i-1]) begin
                sel_idx = CW'(i - 1);
            end
        end
    end

    // Next-state and registered-output logic; select beats abort beats timeout.
    always_comb begin
        state_d   = state_q;
        mask_d    = mask_q;
        timer_d   = timer_q;
        spk_cnt_d = spk_cnt_q;
        sparkle_d = sparkle_q;
        valid_d   = valid_q;
        choice_d  = choice_q;
        timeout_d = timeout_q;
        abort_d   = 1'b0;

        case (state_q)
            S_IDLE: begin
                if (i_start && (|i_mask)) begin
                    state_d   = S_WAIT;
                    mask_d    = i_mask;
                    timer_d   = '0;
                    spk_cnt_d = '0;
                    sparkle_d = 1'b1;
                end
            end
            S_WAIT: begin
                if (|hit) begin
                    state_d   = S_REPORT;
                    valid_d   = 1'b1;
                    choice_d  = sel_idx;
                    timeout_d = 1'b0;
                end else if (i_abort) begin
                    state_d = S_IDLE;
                    abort_d = 1'b1;
                end else if (timer_q == 32'(TIMEOUT - 1)) begin
                    state_d   = S_REPORT;
                    valid_d   = 1'b1;
                    choice_d  = '0;
                    timeout_d = 1'b1;
                end else begin
                    timer_d = timer_q + 32'd1;
                    if (spk_cnt_q == SW'(SPARKLE_DIV - 1)) begin
                        spk_cnt_d = '0;
                        sparkle_d = ~sparkle_q;
                    end else begin
                        spk_cnt_d = spk_cnt_q + SW'(1);
                    end
                end
            end
            S_REPORT: begin
                if (i_ready) begin
                    state_d   = S_IDLE;
                    valid_d   = 1'b0;
                    choice_d  = '0;
                    timeout_d = 1'b0;
                end
            end
            default: begin
                state_d = S_IDLE;
                valid_d = 1'b0;
            end
        endcase

        // Outputs tied to the state being entered so they stay registered.
        exist_d = (state_d == S_WAIT) ? mask_d : '0;
        if (state_d != S_WAIT) begin
            sparkle_d = 1'b0;
        end
        busy_d = (state_d != S_IDLE);
    end

    // State and output registers with synchronous active-low reset.
    always_ff @(posedge i_clk) begin
        if (!i_rst_n) begin
            state_q   <= S_IDLE;
            mask_q    <= '0;
            timer_q   <= '0;
            spk_cnt_q <= '0;
            sparkle_q <= 1'b0;
            exist_q   <= '0;
            busy_q    <= 1'b0;
            valid_q   <= 1'b0;
            choice_q  <= '0;
            timeout_q <= 1'b0;
            abort_q   <= 1'b0;
        end else begin
            state_q   <= state_d;
            mask_q    <= mask_d;
            timer_q   <= timer_d;
            spk_cnt_q <= spk_cnt_d;
            sparkle_q <= sparkle_d;
            exist_q   <= exist_d;
            busy_q    <= busy_d;
            valid_q   <= valid_d;
            choice_q  <= choice_d;
            timeout_q <= timeout_d;
            abort_q   <= abort_d;
        end
    end

    assign o_exist   = exist_q;
    assign o_sparkle = sparkle_q;
    assign o_busy    = busy_q;
    assign o_valid   = valid_q;
    assign o_choice  = choice_q;
    assign o_timeout = timeout_q;
    assign o_abort   = abort_q;

endmodule

// File: tb/tb_button_round_ctrl.sv
// Bench for button_round_ctrl: directed round scenarios followed by random
// stimulus, all checked against a round-level behavioural model.
module tb_button_round_ctrl;

    localparam int unsigned NB  = 4;
    localparam int unsigned DIV = 4;
    localparam int unsigned TO  = 20;

    logic       clk = 1'b0;
    logic       rst_n, start, abrt, ready;
    logic [3:0] mask, sel;
    logic [3:0] o_exist;
    logic       o_sparkle, o_busy, o_valid, o_timeout, o_abort;
    logic [1:0] o_choice;

    int n_tests = 0;
    int n_fail  = 0;

    // Model: phase 0=idle, 1=waiting, 2=reporting; m_n = WAIT cycles elapsed.
    int         m_phase = 0;
    int         m_n     = 0;
    logic [3:0] m_mask  = '0;
    logic       m_valid = 1'b0;
    logic       m_tmo   = 1'b0;
    logic       m_abort = 1'b0;
    int         m_choice = 0;

    button_round_ctrl #(
        .N_BTN      (NB),
        .SPARKLE_DIV(DIV),
        .TIMEOUT    (TO)
    ) dut (
        .i_clk    (clk),
        .i_rst_n  (rst_n),
        .i_start  (start),
        .i_mask   (mask),
        .i_select (sel),
        .i_abort  (abrt),
        .i_ready  (ready),
        .o_exist  (o_exist),
        .o_sparkle(o_sparkle),
        .o_busy   (o_busy),
        .o_valid  (o_valid),
        .o_choice (o_choice),
        .o_timeout(o_timeout),
        .o_abort  (o_abort)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_tests++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0d expected %0d (t=%0t)", tag, got, exp, $time);
        end
    endtask

    task automatic model_step;
        logic [3:0] hit, iso;
        if (!rst_n) begin
            m_phase = 0; m_n = 0; m_mask = '0;
            m_valid = 1'b0; m_tmo = 1'b0; m_abort = 1'b0; m_choice = 0;
        end else begin
            m_abort = 1'b0;
            case (m_phase)
                0: if (start && mask != 4'd0) begin
                    m_phase = 1; m_mask = mask; m_n = 0;
                end
                1: begin
                    hit = sel & m_mask;
                    if (hit != 4'd0) begin
                        iso = hit & (~hit + 4'd1);
                        m_phase = 2; m_valid = 1'b1; m_tmo = 1'b0;
                        m_choice = $clog2(iso);
                    end else if (abrt) begin
                        m_phase = 0; m_abort = 1'b1;
                    end else if (m_n == int'(TO) - 1) begin
                        m_phase = 2; m_valid = 1'b1; m_tmo = 1'b1; m_choice = 0;
                    end else begin
                        m_n++;
                    end
                end
                default: if (ready) begin
                    m_phase = 0; m_valid = 1'b0;
                end
            endcase
        end
    endtask

    task automatic check_all;
        logic exp_spk;
        exp_spk = (m_phase == 1) && (((m_n / int'(DIV)) % 2) == 0);
        check("exist",   32'(o_exist),   32'((m_phase == 1) ? m_mask : 4'd0));
        check("sparkle", 32'(o_sparkle), 32'(exp_spk));
        check("busy",    32'(o_busy),    32'(m_phase != 0));
        check("valid",   32'(o_valid),   32'(m_valid));
        check("abort",   32'(o_abort),   32'(m_abort));
        if (m_valid) begin
            check("choice",  32'(o_choice),  32'(m_choice));
            check("timeout", 32'(o_timeout), 32'(m_tmo));
        end
    endtask

    task automatic cycle(input logic s, input logic [3:0] mk, input logic [3:0] sl,
                         input logic ab, input logic rd, input logic rn);
        start = s; mask = mk; sel = sl; abrt = ab; ready = rd; rst_n = rn;
        @(posedge clk);
        model_step();
        #1;
        check_all();
    endtask

    task automatic idle_cycles(input int n);
        for (int i = 0; i < n; i++) cycle(1'b0, 4'd0, 4'd0, 1'b0, 1'b0, 1'b1);
    endtask

    initial begin
        start = 1'b0; mask = '0; sel = '0; abrt = 1'b0; ready = 1'b0; rst_n = 1'b0;
        cycle(1'b0, 4'd0, 4'd0, 1'b0, 1'b0, 1'b0);
        cycle(1'b0, 4'd0, 4'd0, 1'b0, 1'b0, 1'b0);
        check("rst_busy",  32'(o_busy),  32'd0);
        check("rst_valid", 32'(o_valid), 32'd0);

        // Selection on the 5th WAIT cycle, held until ready.
        cycle(1'b1, 4'b1010, 4'd0, 1'b0, 1'b0, 1'b1);
        idle_cycles(4);
        cycle(1'b0, 4'd0, 4'b1000, 1'b0, 1'b0, 1'b1);
        check("sel_choice",  32'(o_choice),  32'd3);
        check("sel_valid",   32'(o_valid),   32'd1);
        check("sel_exist",   32'(o_exist),   32'd0);
        check("sel_timeout", 32'(o_timeout), 32'd0);
        idle_cycles(3);
        check("hold_valid", 32'(o_valid),  32'd1);
        check("hold_choice", 32'(o_choice), 32'd3);
        cycle(1'b0, 4'd0, 4'd0, 1'b0, 1'b1, 1'b1);
        check("drop_valid", 32'(o_valid), 32'd0);

        // Unmasked selects ignored; lowest masked index wins.
        cycle(1'b1, 4'b0110, 4'd0, 1'b0, 1'b0, 1'b1);
        cycle(1'b0, 4'd0, 4'b1001, 1'b0, 1'b0, 1'b1);
        check("unmasked_ign", 32'(o_valid), 32'd0);
        cycle(1'b0, 4'd0, 4'b1111, 1'b0, 1'b0, 1'b1);
        check("lowest_idx", 32'(o_choice), 32'd1);
        cycle(1'b0, 4'd0, 4'd0, 1'b0, 1'b1, 1'b1);

        // Timeout round with sparkle.
        cycle(1'b1, 4'b0001, 4'd0, 1'b0, 1'b0, 1'b1);
        check("spk_first", 32'(o_sparkle), 32'd1);
        idle_cycles(19);
        check("tmo_notyet", 32'(o_valid), 32'd0);
        idle_cycles(1);
        check("tmo_valid",  32'(o_valid),   32'd1);
        check("tmo_flag",   32'(o_timeout), 32'd1);
        check("tmo_choice", 32'(o_choice),  32'd0);
        cycle(1'b0, 4'd0, 4'd0, 1'b0, 1'b1, 1'b1);

        // Select beats abort; abort alone cancels.
        cycle(1'b1, 4'b0001, 4'd0, 1'b0, 1'b0, 1'b1);
        cycle(1'b0, 4'd0, 4'b0001, 1'b1, 1'b0, 1'b1);
        check("prio_abort", 32'(o_abort), 32'd0);
        check("prio_valid", 32'(o_valid), 32'd1);
        cycle(1'b0, 4'd0, 4'd0, 1'b0, 1'b1, 1'b1);
        cycle(1'b1, 4'b0011, 4'd0, 1'b0, 1'b0, 1'b1);
        cycle(1'b0, 4'd0, 4'd0, 1'b1, 1'b0, 1'b1);
        check("abort_pulse", 32'(o_abort), 32'd1);
        check("abort_busy",  32'(o_busy),  32'd0);
        idle_cycles(1);
        check("abort_once", 32'(o_abort), 32'd0);

        // Zero-mask start ignored; start during WAIT ignored.
        cycle(1'b1, 4'b0000, 4'd0, 1'b0, 1'b0, 1'b1);
        check("zero_mask", 32'(o_busy), 32'd0);
        cycle(1'b1, 4'b0011, 4'd0, 1'b0, 1'b0, 1'b1);
        cycle(1'b1, 4'b1100, 4'd0, 1'b0, 1'b0, 1'b1);
        check("restart_ign", 32'(o_exist), 32'd3);
        cycle(1'b0, 4'd0, 4'd0, 1'b1, 1'b0, 1'b1);

        // Reset mid-round.
        cycle(1'b1, 4'b1111, 4'd0, 1'b0, 1'b0, 1'b1);
        idle_cycles(2);
        cycle(1'b0, 4'd0, 4'b0100, 1'b1, 1'b0, 1'b0);
        check("mrst_exist", 32'(o_exist), 32'd0);
        check("mrst_busy",  32'(o_busy),  32'd0);
        idle_cycles(1);
        check("mrst_noabort", 32'(o_abort), 32'd0);
        check("mrst_novalid", 32'(o_valid), 32'd0);

        // Random stimulus.
        for (int i = 0; i < 3000; i++) begin
            logic       s, ab, rd, rn;
            logic [3:0] mk, sl;
            rn = ($urandom_range(0, 199) != 0);
            s  = ($urandom_range(0, 3) == 0);
            mk = 4'($urandom_range(0, 15));
            sl = ($urandom_range(0, 9) == 0) ? 4'($urandom_range(1, 15)) : 4'd0;
            ab = ($urandom_range(0, 19) == 0);
            rd = ($urandom_range(0, 2) == 0);
            cycle(s, mk, sl, ab, rd, rn);
        end

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
